// File: rtl/toggle_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// toggle_pulse_arbiter
//
// Several requesters share one pulse channel into a toggle synchronizer.
// Each request strobe is latched as a pending bit. In IDLE a round-robin pick
// chooses one pending requester. The block then issues a single-cycle pulse
// and enforces an idle gap, so the synchronizer never sees pulses too close
// together. Every output is registered.
//
// Optional feature (macro TOGGLE_PULSE_ARB_ACK_EN):
//   An internal tracker toggles on each issued pulse. After the gap, the FSM
//   waits until the synchronized return toggle (ack_in) matches the tracker,
//   or until ACK_TIMEOUT cycles have passed. A timeout sets the sticky
//   ack_err flag. Without the macro, ack_in is ignored and ack_err stays 0.
//   The port list is the same in both builds.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   GAP_CYCLES   idle cycles enforced after each pulse (1..255)
//   ACK_TIMEOUT  max cycles spent waiting for the return toggle (ACK build)
//
// Ports:
//   clk        clock, rising-edge
//   reset      asynchronous, active-low reset
//   req_in     per-requester single-cycle request strobes
//   ack_in     synchronized return toggle (ACK build only)
//   pend_out   latched pending requests
//   pulse_out  single-cycle pulse to the toggle synchronizer
//   pulse_id   index of the requester served by the current/last pulse
//   done_out   one-hot strobe for the served requester, high with pulse_out
//   busy       high whenever the FSM is not in IDLE
//   ack_err    sticky return-toggle timeout flag
// -----------------------------------------------------------------------------
module toggle_pulse_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 6,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic                       ack_in,
    output logic [NUM_REQ-1:0]         pend_out,
    output logic                       pulse_out,
    output logic [$clog2(NUM_REQ)-1:0] pulse_id,
    output logic [NUM_REQ-1:0]         done_out,
    output logic                       busy,
    output logic                       ack_err
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_WAIT_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] pend_q,  pend_d;
    logic               pulse_q, pulse_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic [NUM_REQ-1:0] done_q,  done_d;
    logic               busy_q,  busy_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    // Rotating priority: the requester at ptr_q has highest priority.
    logic [ID_W-1:0]    ptr_q,   ptr_d;
    logic               err_q,   err_d;
`ifdef TOGGLE_PULSE_ARB_ACK_EN
    logic               trk_q,   trk_d;
`else
    logic               unused_ack;
    assign unused_ack = ack_in;
`endif

    // Round-robin pick over the current pending bits, starting at ptr_q.
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    idx_v;
    logic [NUM_REQ-1:0] clr_v;

    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        idx_v     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_v = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_valid && pend_q[idx_v]) begin
                win_valid = 1'b1;
                win_id    = idx_v;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
`ifdef TOGGLE_PULSE_ARB_ACK_EN
        trk_d   = trk_q;
`endif

        // The served bit clears when leaving ISSUE. A new strobe for that
        // bit in the same cycle is ORed in afterwards, so the new request wins.
        clr_v = '0;
        if (state_q == ST_ISSUE) begin
            clr_v[id_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr_v) | req_in;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
                ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
`ifdef TOGGLE_PULSE_ARB_ACK_EN
                trk_d   = ~trk_q;
`endif
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
`ifdef TOGGLE_PULSE_ARB_ACK_EN
                    state_d = ST_WAIT_ACK;
                    cnt_d   = CNT_W'(ACK_TIMEOUT - 1);
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_ACK: begin
`ifdef TOGGLE_PULSE_ARB_ACK_EN
                if (ack_in == trk_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The outputs are decoded from the next state, so each one is
        // registered and lines up with the state it describes.
        pulse_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
        id_d    = pulse_d ? win_id : id_q;
        done_d  = '0;
        if (pulse_d) begin
            done_d[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            pulse_q <= 1'b0;
            id_q    <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
`ifdef TOGGLE_PULSE_ARB_ACK_EN
            trk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
            id_q    <= id_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
`ifdef TOGGLE_PULSE_ARB_ACK_EN
            trk_q   <= trk_d;
`endif
        end
    end

    assign pend_out  = pend_q;
    assign pulse_out = pulse_q;
    assign pulse_id  = id_q;
    assign done_out  = done_q;
    assign busy      = busy_q;
    assign ack_err   = err_q;

endmodule

// File: tb/tb_toggle_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// tb_toggle_pulse_arbiter
//
// Self-checking bench for toggle_pulse_arbiter (NUM_REQ=4, GAP_CYCLES=6).
// The reference model is built from timing rules, not from the FSM:
//   - A pulse can fire only when something is pending and at least
//     SPACING cycles have passed since the previous pulse.
//   - The winner is the first pending requester after the last one served.
// Stimulus: directed sequences, then random requests with occasional
// asynchronous resets. If TOGGLE_PULSE_ARB_ACK_EN is defined, ack_in
// normally returns the toggle at once, and one directed test checks the
// timeout.
// -----------------------------------------------------------------------------
module tb_toggle_pulse_arbiter;

    localparam int NREQ    = 4;
    localparam int GAP     = 6;
    localparam int ACK_TO  = 255;
`ifdef TOGGLE_PULSE_ARB_ACK_EN
    localparam int SPACING   = GAP + 3;
    localparam int BUSY_SPAN = GAP + 1;
`else
    localparam int SPACING   = GAP + 2;
    localparam int BUSY_SPAN = GAP;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NREQ-1:0] req_in = '0;
    logic            ack_in = 1'b0;
    logic [NREQ-1:0] pend_out;
    logic            pulse_out;
    logic [1:0]      pulse_id;
    logic [NREQ-1:0] done_out;
    logic            busy;
    logic            ack_err;

    toggle_pulse_arbiter #(
        .NUM_REQ    (NREQ),
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_in   (req_in),
        .ack_in   (ack_in),
        .pend_out (pend_out),
        .pulse_out(pulse_out),
        .pulse_id (pulse_id),
        .done_out (done_out),
        .busy     (busy),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    logic [NREQ-1:0] m_pend;
    logic [1:0]      m_id;
    logic            m_pulse;
    logic [NREQ-1:0] m_done;
    int              m_ptr;
    int              m_last;
    int              m_pulses;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] p, input int start);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (start + k) % NREQ;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend   = '0;
        m_id     = '0;
        m_pulse  = 1'b0;
        m_done   = '0;
        m_ptr    = 0;
        m_last   = cyc - 1000;
        m_pulses = 0;
    endtask

    // Advance the model across one rising edge. rq is the request value
    // sampled at that edge.
    task automatic model_edge(input logic [NREQ-1:0] rq);
        logic [NREQ-1:0] nxt;
        int w;
        cyc++;
        nxt = m_pend;
        if (m_pulse) nxt[m_id] = 1'b0;
        nxt = nxt | rq;
        w = -1;
        if (m_pend != '0 && (cyc - m_last) >= SPACING) w = pick(m_pend, m_ptr);
        m_pulse = (w >= 0);
        m_done  = '0;
        if (w >= 0) begin
            m_id      = 2'(w);
            m_done[w] = 1'b1;
            m_ptr     = (w + 1) % NREQ;
            m_last    = cyc;
            m_pulses++;
        end
        m_pend = nxt;
    endtask

    task automatic compare_all();
        check_eq("pend_out",  32'(pend_out),  32'(m_pend));
        check_eq("pulse_out", 32'(pulse_out), 32'(m_pulse));
        check_eq("pulse_id",  32'(pulse_id),  32'(m_id));
        check_eq("done_out",  32'(done_out),  32'(m_done));
        check_eq("busy",      32'(busy),      32'((cyc - m_last) <= BUSY_SPAN));
        check_eq("ack_err",   32'(ack_err),   32'd0);
    endtask

    task automatic step(input logic [NREQ-1:0] rq);
        req_in = rq;
        @(posedge clk);
        model_edge(rq);
        #1;
        // Return the toggle right away: it matches the tracker, which
        // flips once per pulse.
        ack_in = m_pulses[0];
        compare_all();
    endtask

    // Assert reset between edges, check the outputs clear at once, then
    // release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        req_in = '0;
        reset  = 1'b0;
        #1;
        ack_in = 1'b0;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rq;
        int mode;

        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        do_reset();

        // A single request: pend, then pulse, then clear.
        step(4'b0001);
        step(4'b0000);
        repeat (10) step(4'b0000);

        // All four pending: four pulses, served in order with fixed spacing.
        step(4'b1111);
        repeat (40) step(4'b0000);

        // Requester 2 re-requests during its own ISSUE cycle.
        do_reset();
        step(4'b0100);
        step(4'b0000);
        for (int n = 0; n < 25; n++) begin
            step((m_pulse && m_id == 2'd2 && n < 5) ? 4'b0100 : 4'b0000);
        end

        // Reset while in GAP with pending requests 1010.
        do_reset();
        step(4'b0001);
        step(4'b0000);
        step(4'b1010);
        step(4'b0000);
        check_eq("pend_before_reset", 32'(pend_out), 32'hA);
        do_reset();
        repeat (15) step(4'b0000);

`ifdef TOGGLE_PULSE_ARB_ACK_EN
        // ack_in is held constant, so the wait times out and ack_err sticks.
        do_reset();
        step(4'b0001);
        step(4'b0000);
        check_eq("to_pulse", 32'(pulse_out), 32'd1);
        for (int k = 1; k <= GAP + ACK_TO + 2; k++) begin
            req_in = '0;
            @(posedge clk);
            #1;
            ack_in = 1'b0;
            if (k == GAP + ACK_TO) begin
                check_eq("to_err_early", 32'(ack_err), 32'd0);
                check_eq("to_busy_early", 32'(busy), 32'd1);
            end
            if (k == GAP + ACK_TO + 1) begin
                check_eq("to_err_set", 32'(ack_err), 32'd1);
                check_eq("to_busy_done", 32'(busy), 32'd0);
            end
            if (k == GAP + ACK_TO + 2) check_eq("to_err_sticky", 32'(ack_err), 32'd1);
        end
        do_reset();
`endif

        // Random phase: dense, sparse and quiet request patterns, with
        // occasional resets mid-operation.
        do_reset();
        mode = 0;
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       rq = 4'($urandom);
                1:       rq = 4'($urandom) & 4'($urandom) & 4'($urandom);
                default: rq = '0;
            endcase
            if ($urandom_range(0, 149) == 0) do_reset();
            step(rq);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
